// File: rtl/seg7_pkg.sv
// Shared types and constants for the counter display slice:
// converter state encoding and active-low 7-segment digit codes.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } bcd_state_e;

  // seg[6:0] = {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 8-bit binary to 12-bit BCD in 8 shifts,
// result register loaded and done pulsed on the final state.
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [11:0] bcd,
  output logic        done
);

  bcd_state_e  state_q, state_d;
  logic [7:0]  bin_q, bin_d;
  logic [11:0] acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [11:0] bcd_q, bcd_d;
  logic        done_q, done_d;
  logic [11:0] adj;

  assign adj = {add3(acc_q[11:8]),
                add3(acc_q[7:4]),
                add3(acc_q[3:0])};

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          bin_d   = in_data;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        {acc_d, bin_d} = {adj, bin_q} << 1;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = ST_DONE;
      end
      ST_DONE: begin
        bcd_d   = acc_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  assign in_ready = (state_q == ST_IDLE);
  assign bcd      = bcd_q;
  assign done     = done_q;

endmodule

// File: rtl/count_display_seg7.sv
// Counter value to 3-digit multiplexed 7-segment display with
// optional leading-zero blanking.
module count_display_seg7
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV   = 50000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] value_in,
  input  logic       value_valid,
  output logic       value_ready,
  output logic       conv_done,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam logic [15:0] REF_MAX = 16'(REFRESH_DIV - 1);

  logic [11:0] disp;
  logic [15:0] refresh_q, refresh_d;
  logic [1:0]  digit_q, digit_d;
  logic [3:0]  nib;
  logic        blank;

  bin2bcd_seq u_bcd (
    .clk      (clk),
    .reset    (reset),
    .in_valid (value_valid),
    .in_data  (value_in),
    .in_ready (value_ready),
    .bcd      (disp),
    .done     (conv_done)
  );

  always_comb begin
    refresh_d = refresh_q + 16'd1;
    digit_d   = digit_q;
    if (refresh_q == REF_MAX) begin
      refresh_d = '0;
      digit_d   = (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_q <= '0;
      digit_q   <= '0;
    end else begin
      refresh_q <= refresh_d;
      digit_q   <= digit_d;
    end
  end

  always_comb begin
    nib   = disp[11:8];
    blank = 1'b0;
    an    = 4'b1111;
    an[digit_q] = 1'b0;
    case (digit_q)
      2'd0:    nib = disp[3:0];
      2'd1:    nib = disp[7:4];
      default: nib = disp[11:8];
    endcase
    // tens only blanks when hundreds is blank too
    if (BLANK_LEADING) begin
      if (digit_q == 2'd2)
        blank = (disp[11:8] == 4'd0);
      else if (digit_q == 2'd1)
        blank = (disp[11:4] == 8'd0);
    end
    seg = blank ? SEG_BLANK : seg_decode(nib);
  end

endmodule
